syndrome_collect: RTL and testbench

- Downstream of the 22 parallel syndrome lanes in the RS(544,522) decoder.
- Captures the S1..S22 vector at each frame end and computes an error-free flag.
- Holds up to two frames in a 2-entry FIFO and presents them to the key-equation solver over a valid/ready handshake.
- Tags each frame and reports dropped frames, so the back end can tolerate solver stalls.

---
 rtl/syndrome_collect.sv | 133 +++++++++++++
 tb/tb_syndrome_collect.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/syndrome_collect.sv
// Two-entry syndrome FIFO between the RS(544,522) syndrome lanes and the key-equation solver.
// Optional frame statistics outputs are enabled with `define SYN_COLLECT_STATS_EN.
module syndrome_collect #(
    parameter int J     = 22,
    parameter int SYM_W = 10,
    parameter int TAG_W = 8,
    parameter int DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               s_valid_i,
    input  logic [J*SYM_W-1:0] s_i,
    output logic               syn_valid_o,
    input  logic               syn_ready_i,
    output logic [J*SYM_W-1:0] syn_o,
    output logic               syn_zero_o,
    output logic [TAG_W-1:0]   syn_tag_o,
    output logic               drop_o,
    output logic               ovf_o,
    input  logic               ovf_clr_i
`ifdef SYN_COLLECT_STATS_EN
   ,output logic [31:0]        frames_total_o,
    output logic [31:0]        frames_zero_o
`endif
);

    localparam int VW = J * SYM_W;

    generate
        if (DEPTH != 2) begin : g_depth_check
            $error("syndrome_collect: only DEPTH == 2 is supported");
        end
    endgenerate

    logic [VW-1:0]    vec_q  [2];
    logic             zero_q [2];
    logic [TAG_W-1:0] tag_q  [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [TAG_W-1:0] tag_cnt_q;
    logic             drop_q;
    logic             ovf_q;

    logic pop;
    logic push;
    logic drop;

    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign pop  = (count_q != 2'd0) && syn_ready_i;
    assign push = s_valid_i && ((count_q != 2'd2) || pop);
    assign drop = s_valid_i && (count_q == 2'd2) && !pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vec_q[0]  <= '0;
            vec_q[1]  <= '0;
            zero_q[0] <= 1'b0;
            zero_q[1] <= 1'b0;
            tag_q[0]  <= '0;
            tag_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            tag_cnt_q <= '0;
            drop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (push) begin
                vec_q[wr_ptr_q]  <= s_i;
                zero_q[wr_ptr_q] <= ~|s_i;
                tag_q[wr_ptr_q]  <= tag_cnt_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            // Dropped frames still consume a tag so the solver sees the gap.
            if (s_valid_i) begin
                tag_cnt_q <= tag_cnt_q + 1'b1;
            end
            drop_q <= drop;
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign syn_valid_o = (count_q != 2'd0);
    assign syn_o       = vec_q[rd_ptr_q];
    assign syn_zero_o  = zero_q[rd_ptr_q];
    assign syn_tag_o   = tag_q[rd_ptr_q];
    assign drop_o      = drop_q;
    assign ovf_o       = ovf_q;

`ifdef SYN_COLLECT_STATS_EN
    logic [31:0] total_q;
    logic [31:0] zero_cnt_q;
    logic        zero_inc;

    assign zero_inc = push && ~|s_i;

    // A clear coinciding with an increment leaves the counter at one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            total_q    <= '0;
            zero_cnt_q <= '0;
        end else begin
            if (ovf_clr_i) begin
                total_q <= {31'd0, s_valid_i};
            end else if (s_valid_i && (total_q != 32'hFFFF_FFFF)) begin
                total_q <= total_q + 32'd1;
            end
            if (ovf_clr_i) begin
                zero_cnt_q <= {31'd0, zero_inc};
            end else if (zero_inc && (zero_cnt_q != 32'hFFFF_FFFF)) begin
                zero_cnt_q <= zero_cnt_q + 32'd1;
            end
        end
    end

    assign frames_total_o = total_q;
    assign frames_zero_o  = zero_cnt_q;
`endif

endmodule

// File: tb/tb_syndrome_collect.sv
// Self-checking bench for syndrome_collect: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_syndrome_collect;

    typedef logic [219:0] vec_t;

    typedef struct {
        bit          rst;
        bit          sv;
        vec_t        s;
        bit          rdy;
        bit          clr;
        bit          e_valid;
        vec_t        e_vec;
        bit          e_zero;
        logic [7:0]  e_tag;
        bit          e_drop;
        bit          e_ovf;
    } row_t;

    typedef struct {
        vec_t       vec;
        bit         zero;
        logic [7:0] tag;
    } ent_t;

    logic        clk_i;
    logic        rst_ni;
    logic        s_valid_i;
    vec_t        s_i;
    logic        syn_valid_o;
    logic        syn_ready_i;
    vec_t        syn_o;
    logic        syn_zero_o;
    logic [7:0]  syn_tag_o;
    logic        drop_o;
    logic        ovf_o;
    logic        ovf_clr_i;
`ifdef SYN_COLLECT_STATS_EN
    logic [31:0] frames_total_o;
    logic [31:0] frames_zero_o;
`endif

    int checks = 0;
    int errors = 0;

    ent_t   mq[$];
    int     m_tag;
    bit     m_ovf;
    bit     m_drop;
    longint m_tot;
    longint m_zer;

    row_t tbl[$];

    syndrome_collect dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .s_valid_i   (s_valid_i),
        .s_i         (s_i),
        .syn_valid_o (syn_valid_o),
        .syn_ready_i (syn_ready_i),
        .syn_o       (syn_o),
        .syn_zero_o  (syn_zero_o),
        .syn_tag_o   (syn_tag_o),
        .drop_o      (drop_o),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i)
`ifdef SYN_COLLECT_STATS_EN
       ,.frames_total_o (frames_total_o),
        .frames_zero_o  (frames_zero_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_tag  = 0;
        m_ovf  = 1'b0;
        m_drop = 1'b0;
        m_tot  = 0;
        m_zer  = 0;
    endtask

    // Reference behaviour: a bounded queue of frames, a free-running tag and a sticky flag.
    task automatic model_step(input bit sv, input vec_t s, input bit rdy, input bit clr);
        bit pop;
        bit drp;
        ent_t e;
        pop = (mq.size() != 0) && rdy;
        drp = sv && (mq.size() == 2) && !pop;
        if (pop) void'(mq.pop_front());
        if (sv && !drp) begin
            e.vec  = s;
            e.zero = (s == '0);
            e.tag  = m_tag[7:0];
            mq.push_back(e);
        end
        if (clr) m_tot = sv ? 1 : 0;
        else if (sv && m_tot < 64'hFFFF_FFFF) m_tot++;
        if (clr) m_zer = (sv && !drp && s == '0) ? 1 : 0;
        else if (sv && !drp && s == '0 && m_zer < 64'hFFFF_FFFF) m_zer++;
        if (sv) m_tag = (m_tag + 1) % 256;
        if (drp) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_drop = drp;
    endtask

    task automatic applyStimulus(input bit rst, input bit sv, input vec_t s, input bit rdy, input bit clr);
        @(negedge clk_i);
        rst_ni      = !rst;
        s_valid_i   = sv;
        s_i         = s;
        syn_ready_i = rdy;
        ovf_clr_i   = clr;
        @(posedge clk_i);
        if (rst) model_reset();
        else model_step(sv, s, rdy, clr);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".valid"}, vec_t'(syn_valid_o), vec_t'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk({tag, ".vec"},  syn_o, mq[0].vec);
            chk({tag, ".zero"}, vec_t'(syn_zero_o), vec_t'(mq[0].zero));
            chk({tag, ".tag"},  vec_t'(syn_tag_o), vec_t'(mq[0].tag));
        end
        chk({tag, ".drop"}, vec_t'(drop_o), vec_t'(m_drop));
        chk({tag, ".ovf"},  vec_t'(ovf_o), vec_t'(m_ovf));
`ifdef SYN_COLLECT_STATS_EN
        chk({tag, ".total"}, vec_t'(frames_total_o), vec_t'(m_tot));
        chk({tag, ".zcnt"},  vec_t'(frames_zero_o), vec_t'(m_zer));
`endif
    endtask

    function automatic row_t mk(bit rst, bit sv, vec_t s, bit rdy, bit clr,
                                bit ev, vec_t evec, bit ez, int et, bit ed, bit eo);
        row_t r;
        r.rst = rst; r.sv = sv; r.s = s; r.rdy = rdy; r.clr = clr;
        r.e_valid = ev; r.e_vec = evec; r.e_zero = ez; r.e_tag = et[7:0];
        r.e_drop = ed; r.e_ovf = eo;
        return r;
    endfunction

    vec_t f_s1, f_s22, fa, fb, fc, fd, z;

    initial begin
        z     = '0;
        f_s1  = vec_t'(10'h001);
        f_s22 = vec_t'(10'h3FF) << 210;
        fa    = vec_t'(10'h123);
        fb    = vec_t'(10'h2A5) << 50;
        fc    = vec_t'(10'h07F) << 100;
        fd    = vec_t'(1) << 219;

        rst_ni = 1'b0; s_valid_i = 1'b0; s_i = '0; syn_ready_i = 1'b0; ovf_clr_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.valid", vec_t'(syn_valid_o), 0);
        chk("rst.vec",   syn_o, 0);
        chk("rst.zero",  vec_t'(syn_zero_o), 0);
        chk("rst.tag",   vec_t'(syn_tag_o), 0);
        chk("rst.drop",  vec_t'(drop_o), 0);
        chk("rst.ovf",   vec_t'(ovf_o), 0);

        // rst sv s rdy clr | valid vec zero tag drop ovf
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, z, 1, 0, 0, z, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, f_s1,  1, 0, 1, f_s1,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, z,     1, 0, 0, z,     0, 0, 0, 0));
        tbl.push_back(mk(0, 1, z,     0, 0, 1, z,     1, 1, 0, 0));
        tbl.push_back(mk(0, 1, f_s22, 1, 0, 1, f_s22, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, z,     1, 0, 0, z,     0, 0, 0, 0));
        tbl.push_back(mk(1, 0, z,     0, 0, 0, z,     0, 0, 0, 0));
        tbl.push_back(mk(0, 1, fa,    0, 0, 1, fa,    0, 0, 0, 0));
        tbl.push_back(mk(0, 1, fb,    0, 0, 1, fa,    0, 0, 0, 0));
        tbl.push_back(mk(0, 1, fc,    1, 0, 1, fb,    0, 1, 0, 0));
        tbl.push_back(mk(0, 0, z,     1, 0, 1, fc,    0, 2, 0, 0));
        tbl.push_back(mk(0, 0, z,     1, 0, 0, z,     0, 0, 0, 0));
        tbl.push_back(mk(0, 1, fa,    0, 0, 1, fa,    0, 3, 0, 0));
        tbl.push_back(mk(0, 1, fb,    0, 0, 1, fa,    0, 3, 0, 0));
        tbl.push_back(mk(0, 1, fc,    0, 0, 1, fa,    0, 3, 1, 1));
        tbl.push_back(mk(0, 0, z,     0, 0, 1, fa,    0, 3, 0, 1));
        tbl.push_back(mk(0, 0, z,     0, 1, 1, fa,    0, 3, 0, 0));
        tbl.push_back(mk(0, 1, fd,    0, 1, 1, fa,    0, 3, 1, 1));
        tbl.push_back(mk(0, 0, z,     1, 0, 1, fb,    0, 4, 0, 1));
        tbl.push_back(mk(0, 0, z,     1, 0, 0, z,     0, 0, 0, 1));
        tbl.push_back(mk(0, 1, fd,    1, 0, 1, fd,    0, 7, 0, 1));
        tbl.push_back(mk(0, 0, z,     1, 0, 0, z,     0, 0, 0, 1));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rst, tbl[i].sv, tbl[i].s, tbl[i].rdy, tbl[i].clr);
            checkOutput($sformatf("row%0d", i));
            chk($sformatf("row%0d.valid", i), vec_t'(syn_valid_o), vec_t'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d.vec", i),  syn_o, tbl[i].e_vec);
                chk($sformatf("row%0d.zero", i), vec_t'(syn_zero_o), vec_t'(tbl[i].e_zero));
                chk($sformatf("row%0d.tag", i),  vec_t'(syn_tag_o), vec_t'(tbl[i].e_tag));
            end
            chk($sformatf("row%0d.drop", i), vec_t'(drop_o), vec_t'(tbl[i].e_drop));
            chk($sformatf("row%0d.ovf", i),  vec_t'(ovf_o), vec_t'(tbl[i].e_ovf));
        end

        // Backpressure with frames 17 cycles apart.
        applyStimulus(1, 0, z, 0, 0);
        applyStimulus(0, 1, fa, 0, 0);
        chk("bp.tagA", vec_t'(syn_tag_o), 0);
        for (int k = 0; k < 2; k++) begin
            repeat (16) begin
                applyStimulus(0, 0, z, 0, 0);
                checkOutput("bp.hold");
                chk("bp.headA", syn_o, fa);
            end
            applyStimulus(0, 1, (k == 0) ? fb : fc, 0, 0);
            checkOutput("bp.push");
        end
        chk("bp.drop", vec_t'(drop_o), 1);
        chk("bp.ovf",  vec_t'(ovf_o), 1);
        applyStimulus(0, 0, z, 1, 0);
        chk("bp.dropOnce", vec_t'(drop_o), 0);
        chk("bp.popB", syn_o, fb);
        chk("bp.tagB", vec_t'(syn_tag_o), 1);
        applyStimulus(0, 0, z, 1, 0);
        chk("bp.empty", vec_t'(syn_valid_o), 0);
        applyStimulus(0, 1, fd, 0, 0);
        checkOutput("bp.D");
        chk("bp.tagD", vec_t'(syn_tag_o), 3);

        // Reset asserted mid-cycle with two frames stored.
        applyStimulus(0, 1, fa, 0, 0);
        chk("mid.full", vec_t'(syn_valid_o), 1);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("mid.validLow", vec_t'(syn_valid_o), 0);
        model_reset();
        @(posedge clk_i);
        applyStimulus(0, 1, fb, 0, 0);
        checkOutput("mid.after");
        chk("mid.tag0", vec_t'(syn_tag_o), 0);
        applyStimulus(0, 0, z, 1, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            vec_t rs;
            rs = '0;
            if ($urandom_range(0, 3) != 0) begin
                for (int j = 0; j < 22; j++) rs[j*10 +: 10] = 10'($urandom_range(0, 1023));
            end
            applyStimulus(0, $urandom_range(0, 9) < 4, rs,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
            checkOutput("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
